// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the I/D cache requesters, the arbiter and memory.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface mem_arbiter_if;
  logic         i_req_valid_i;
  logic         i_req_ready_o;
  logic [31:0]  i_req_addr_i;
  logic         i_rsp_valid_o;
  logic         i_rsp_ready_i;
  logic [127:0] i_rsp_line_o;
  logic [31:0]  i_rsp_addr_o;
  logic         i_rsp_err_o;

  logic         d_req_valid_i;
  logic         d_req_ready_o;
  logic [31:0]  d_req_addr_i;
  logic         d_req_we_i;
  logic [127:0] d_req_wdata_i;
  logic         d_rsp_valid_o;
  logic         d_rsp_ready_i;
  logic [127:0] d_rsp_line_o;
  logic [31:0]  d_rsp_addr_o;
  logic         d_rsp_err_o;

  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic [31:0]  mem_addr_o;
  logic         mem_we_o;
  logic [127:0] mem_wdata_o;
  logic         mem_rsp_valid_i;
  logic         mem_rsp_ready_o;
  logic [127:0] mem_rsp_line_i;

  modport slave (
    input  i_req_valid_i, i_req_addr_i, i_rsp_ready_i,
    input  d_req_valid_i, d_req_addr_i, d_req_we_i, d_req_wdata_i, d_rsp_ready_i,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_line_i,
    output i_req_ready_o, i_rsp_valid_o, i_rsp_line_o, i_rsp_addr_o, i_rsp_err_o,
    output d_req_ready_o, d_rsp_valid_o, d_rsp_line_o, d_rsp_addr_o, d_rsp_err_o,
    output mem_req_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_rsp_ready_o
  );

  modport master (
    output i_req_valid_i, i_req_addr_i, i_rsp_ready_i,
    output d_req_valid_i, d_req_addr_i, d_req_we_i, d_req_wdata_i, d_rsp_ready_i,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_line_i,
    input  i_req_ready_o, i_rsp_valid_o, i_rsp_line_o, i_rsp_addr_o, i_rsp_err_o,
    input  d_req_ready_o, d_rsp_valid_o, d_rsp_line_o, d_rsp_addr_o, d_rsp_err_o,
    input  mem_req_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_rsp_ready_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 128-bit line memory port between I-refill and D requesters,
// one transaction outstanding, with a response timeout that returns an error line.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DELIVER} state_t;

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          owner_d_q;   // 1 = D owns the current transaction
  logic          last_d_q;    // 1 = D was granted last
  logic          grant_i, grant_d, timeout, owner_rsp_ready;

  logic         mem_req_valid_q, mem_we_q;
  logic [31:0]  mem_addr_q, rsp_addr_q;
  logic [127:0] mem_wdata_q, rsp_line_q;
  logic         i_rsp_valid_q, d_rsp_valid_q, rsp_err_q;

  always_comb begin
    grant_i         = bus.i_req_valid_i && (!bus.d_req_valid_i || last_d_q);
    grant_d         = bus.d_req_valid_i && (!bus.i_req_valid_i || !last_d_q);
    timeout         = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST) && !bus.mem_rsp_valid_i;
    owner_rsp_ready = owner_d_q ? bus.d_rsp_ready_i : bus.i_rsp_ready_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (grant_i || grant_d)                 state_d = ISSUE;
      ISSUE:    if (bus.mem_req_ready_i)                state_d = WAIT_RSP;
      WAIT_RSP: if (bus.mem_rsp_valid_i || timeout)     state_d = DELIVER;
      DELIVER:  if (owner_rsp_ready)                    state_d = IDLE;
      default:                                          state_d = IDLE;
    endcase
  end

  // Request readies are masked by reset so nothing looks accepted while held in reset.
  always_comb begin
    bus.i_req_ready_o   = rstn_i && (state_q == IDLE) && grant_i;
    bus.d_req_ready_o   = rstn_i && (state_q == IDLE) && grant_d;
    bus.mem_rsp_ready_o = (state_q == WAIT_RSP);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q           <= '0;
      owner_d_q       <= 1'b0;
      last_d_q        <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      rsp_addr_q      <= '0;
      rsp_line_q      <= '0;
      rsp_err_q       <= 1'b0;
      i_rsp_valid_q   <= 1'b0;
      d_rsp_valid_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (grant_i || grant_d) begin
          owner_d_q       <= grant_d;
          last_d_q        <= grant_d;
          mem_req_valid_q <= 1'b1;
          mem_addr_q      <= (grant_d ? bus.d_req_addr_i : bus.i_req_addr_i) & 32'hFFFF_FFF0;
          mem_we_q        <= grant_d && bus.d_req_we_i;
          mem_wdata_q     <= grant_d ? bus.d_req_wdata_i : '0;
        end
        ISSUE: if (bus.mem_req_ready_i) begin
          mem_req_valid_q <= 1'b0;
          cnt_q           <= '0;
        end
        WAIT_RSP: begin
          if (bus.mem_rsp_valid_i || timeout) begin
            rsp_line_q    <= bus.mem_rsp_valid_i ? bus.mem_rsp_line_i : '0;
            rsp_err_q     <= !bus.mem_rsp_valid_i;
            rsp_addr_q    <= mem_addr_q;
            i_rsp_valid_q <= !owner_d_q;
            d_rsp_valid_q <= owner_d_q;
          end else if (TIMEOUT_CYCLES != 0) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DELIVER: if (owner_rsp_ready) begin
          i_rsp_valid_q <= 1'b0;
          d_rsp_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req_valid_o = mem_req_valid_q;
  assign bus.mem_addr_o      = mem_addr_q;
  assign bus.mem_we_o        = mem_we_q;
  assign bus.mem_wdata_o     = mem_wdata_q;
  assign bus.i_rsp_valid_o   = i_rsp_valid_q;
  assign bus.i_rsp_line_o    = rsp_line_q;
  assign bus.i_rsp_addr_o    = rsp_addr_q;
  assign bus.i_rsp_err_o     = rsp_err_q;
  assign bus.d_rsp_valid_o   = d_rsp_valid_q;
  assign bus.d_rsp_line_o    = rsp_line_q;
  assign bus.d_rsp_addr_o    = rsp_addr_q;
  assign bus.d_rsp_err_o     = rsp_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter against a transaction-level model:
// round-robin grant rule, a line store for expected read data, and timeout error lines.
module tb_mem_arbiter;
  localparam int unsigned TO = 8;

  logic clk_i = 1'b0;
  logic rstn_i;
  int   checks = 0;
  int   errors = 0;
  bit   lg_d = 1'b1;                        // model: last grant was D
  logic [127:0] mstore [logic [31:0]];      // model: memory contents by aligned address

  mem_arbiter_if bus ();
  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (.clk_i(clk_i), .rstn_i(rstn_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] rnd_addr();
    return 32'h0001_0000 | ($urandom_range(0, 15) << 4) | 32'($urandom_range(0, 15));
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    if (!mstore.exists(a)) mstore[a] = rnd_line();
    return mstore[a];
  endfunction

  task automatic new_i(input bit v);
    bus.i_req_valid_i = v;
    bus.i_req_addr_i  = rnd_addr();
  endtask

  task automatic new_d(input bit v);
    bus.d_req_valid_i = v;
    bus.d_req_addr_i  = rnd_addr();
    bus.d_req_we_i    = 1'($urandom_range(0, 1));
    bus.d_req_wdata_i = rnd_line();
  endtask

  // One transaction from the IDLE cycle to the return to IDLE. rsp_lat < 0: memory never answers.
  task automatic txn(input int mem_wait, input int rsp_lat, input int hold,
                     input bit keep_i, input bit keep_d);
    bit gd, we, eerr;
    logic [31:0]  a;
    logic [127:0] wd, eline;
    int n;
    #1;
    gd = (bus.i_req_valid_i && bus.d_req_valid_i) ? !lg_d : bus.d_req_valid_i;
    chk("i_req_ready", bus.i_req_ready_o, !gd);
    chk("d_req_ready", bus.d_req_ready_o, gd);
    chk("idle_mem_valid", bus.mem_req_valid_o, 0);
    a  = (gd ? bus.d_req_addr_i : bus.i_req_addr_i) & 32'hFFFF_FFF0;
    we = gd && bus.d_req_we_i;
    wd = bus.d_req_wdata_i;
    lg_d = gd;
    eline = we ? '0 : mem_line(a);
    step();
    if (gd) new_d(keep_d); else new_i(keep_i);
    for (int k = 0; k <= mem_wait; k++) begin
      bus.mem_req_ready_i = (k == mem_wait);
      #1;
      chk("issue_valid", bus.mem_req_valid_o, 1);
      chk("issue_addr", bus.mem_addr_o, a);
      chk("issue_we", bus.mem_we_o, we);
      if (we) chk("issue_wdata", bus.mem_wdata_o, wd);
      chk("issue_rdy", {bus.i_req_ready_o, bus.d_req_ready_o, bus.mem_rsp_ready_o}, 0);
      step();
    end
    bus.mem_req_ready_i = 1'b0;
    if (rsp_lat >= 0) begin
      for (int k = 0; k < rsp_lat; k++) begin
        #1;
        chk("wait_rdy", bus.mem_rsp_ready_o, 1);
        chk("early_rsp", {bus.i_rsp_valid_o, bus.d_rsp_valid_o}, 0);
        step();
      end
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rsp_line_i  = we ? rnd_line() : mem_line(bus.mem_addr_o);
      #1;
      chk("wait_rdy", bus.mem_rsp_ready_o, 1);
      step();
      bus.mem_rsp_valid_i = 1'b0;
      if (we) mstore[a] = wd;
      eerr = 1'b0;
    end else begin
      n = 0;
      while (bus.i_rsp_valid_o === 1'b0 && bus.d_rsp_valid_o === 1'b0 && n < 40) begin
        chk("to_rdy", bus.mem_rsp_ready_o, 1);
        n++;
        step();
      end
      chk("to_cycles", n, TO);
      eline = '0;
      eerr  = 1'b1;
    end
    for (int k = 0; k <= hold; k++) begin
      if (gd) bus.d_rsp_ready_i = (k == hold); else bus.i_rsp_ready_i = (k == hold);
      if (rsp_lat < 0 && k >= 2) begin
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_line_i  = rnd_line();
      end
      #1;
      chk("own_valid", gd ? bus.d_rsp_valid_o : bus.i_rsp_valid_o, 1);
      chk("other_valid", gd ? bus.i_rsp_valid_o : bus.d_rsp_valid_o, 0);
      if (!we || eerr) chk("rsp_line", gd ? bus.d_rsp_line_o : bus.i_rsp_line_o, eline);
      chk("rsp_addr", gd ? bus.d_rsp_addr_o : bus.i_rsp_addr_o, a);
      chk("rsp_err", gd ? bus.d_rsp_err_o : bus.i_rsp_err_o, eerr);
      chk("deliver_rdy", {bus.i_req_ready_o, bus.d_req_ready_o, bus.mem_rsp_ready_o}, 0);
      step();
    end
    bus.i_rsp_ready_i   = 1'b0;
    bus.d_rsp_ready_i   = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    chk("rsp_drop", {bus.i_rsp_valid_o, bus.d_rsp_valid_o}, 0);
  endtask

  initial begin
    bit iv, dv;
    rstn_i = 1'b0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_line_i  = '0;
    bus.i_rsp_ready_i   = 1'b0;
    bus.d_rsp_ready_i   = 1'b0;
    new_i(1'b1);
    new_d(1'b1);
    bus.i_req_addr_i = 32'h0000_004C;
    bus.d_req_we_i   = 1'b0;

    // reset with both requesters valid, then I wins the first tie
    step();
    step();
    chk("rst_ready", {bus.i_req_ready_o, bus.d_req_ready_o}, 0);
    chk("rst_mem_valid", bus.mem_req_valid_o, 0);
    rstn_i = 1'b1;
    txn(0, 0, 0, 1'b1, 1'b1);

    // continuous contention alternates grants
    for (int t = 0; t < 6; t++) txn(0, 0, 0, 1'b1, 1'b1);

    // D write with memory stalling the request
    bus.i_req_valid_i = 1'b0;
    bus.d_req_valid_i = 1'b1;
    bus.d_req_addr_i  = 32'h0000_0100;
    bus.d_req_we_i    = 1'b1;
    bus.d_req_wdata_i = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;
    txn(5, 1, 0, 1'b0, 1'b0);

    // timeout on a D read, late response ignored, then a normal I transaction
    new_d(1'b1);
    bus.d_req_we_i = 1'b0;
    txn(0, -1, 4, 1'b0, 1'b0);
    new_i(1'b1);
    txn(0, 2, 0, 1'b0, 1'b0);

    // I response held off while D waits for its turn
    new_d(1'b1);
    txn(0, 0, 0, 1'b0, 1'b0);
    new_i(1'b1);
    new_d(1'b1);
    txn(1, 1, 4, 1'b0, 1'b0);
    txn(0, 0, 0, 1'b0, 1'b0);

    // reset during WAIT_RSP drops the transaction
    new_i(1'b1);
    step();
    bus.i_req_valid_i   = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    step();
    bus.mem_req_ready_i = 1'b0;
    #1;
    chk("pre_rst_wait", bus.mem_rsp_ready_o, 1);
    bus.i_req_valid_i = 1'b1;
    rstn_i = 1'b0;
    lg_d   = 1'b1;
    #1;
    chk("rst_ctrl", {bus.i_req_ready_o, bus.d_req_ready_o, bus.mem_rsp_ready_o, bus.mem_req_valid_o,
                     bus.mem_we_o, bus.i_rsp_valid_o, bus.d_rsp_valid_o, bus.i_rsp_err_o, bus.d_rsp_err_o}, 0);
    chk("rst_addr", {bus.mem_addr_o, bus.i_rsp_addr_o, bus.d_rsp_addr_o}, 0);
    chk("rst_wdata", bus.mem_wdata_o, 0);
    chk("rst_lines", bus.i_rsp_line_o | bus.d_rsp_line_o, 0);
    bus.i_req_valid_i = 1'b0;
    bus.d_req_valid_i = 1'b0;
    step();
    rstn_i = 1'b1;
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_line_i  = rnd_line();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_quiet", {bus.i_rsp_valid_o, bus.d_rsp_valid_o, bus.mem_rsp_ready_o, bus.mem_req_valid_o}, 0);
    end
    bus.mem_rsp_valid_i = 1'b0;
    new_i(1'b1);
    new_d(1'b1);
    txn(0, 0, 0, 1'b0, 1'b1);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      iv = bus.i_req_valid_i;
      dv = bus.d_req_valid_i;
      if (!iv && $urandom_range(0, 1) == 1) new_i(1'b1);
      if (!dv && $urandom_range(0, 1) == 1) new_d(1'b1);
      if (!bus.i_req_valid_i && !bus.d_req_valid_i) new_i(1'b1);
      txn($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
